// File: rtl/fast_pkg.sv
// Shared types and constants for the FAST frame scheduler.
// Coordinates are sized for frames up to 1024x512.
package fast_pkg;

    localparam int unsigned BORDER = 3;
    localparam int unsigned X_W    = 10;
    localparam int unsigned Y_W    = 9;
    localparam int unsigned SCR_W  = 13;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } state_t;

    typedef struct packed {
        logic [X_W-1:0]   x;
        logic [Y_W-1:0]   y;
        logic [SCR_W-1:0] scr;
    } corner_rec_t;

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
    } tag_t;

endpackage

// File: rtl/fast_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count and flush.
// Depth need not be a power of two; pointers wrap explicitly.
module fast_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CW-1:0]    count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign count_o = cnt_q;
    assign rdata_o = mem_q[rptr_q];
    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (flush_i) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (do_push) wptr_d = ptr_inc(wptr_q);
            if (do_pop)  rptr_d = ptr_inc(rptr_q);
            cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            if (do_push) mem_q[wptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/fast_frame_ctrl.sv
// Frame scheduler for the FAST corner pipeline: issues interior windows to the
// detector, qualifies returning results and queues corner records under credit control.
module fast_frame_ctrl
    import fast_pkg::*;
#(
    parameter int unsigned IMG_W       = 640,
    parameter int unsigned IMG_H       = 480,
    parameter int unsigned DET_LAT     = 7,
    parameter int unsigned OFIFO_DEPTH = 16
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic        i_abort,
    input  logic [7:0]  i_thr,
    input  logic [12:0] i_min_score,
    input  logic        i_pix_v,
    output logic        o_pix_rdy,
    output logic        o_det_v,
    output logic [7:0]  o_det_thr,
    input  logic        i_det_v,
    input  logic [12:0] i_det_scr,
    input  logic        i_det_corner,
    output logic        o_crn_v,
    input  logic        i_crn_rdy,
    output logic [9:0]  o_crn_x,
    output logic [8:0]  o_crn_y,
    output logic [12:0] o_crn_scr,
    output logic        o_busy,
    output logic        o_done,
    output logic [18:0] o_crn_count,
    output logic        o_err
);

    localparam int unsigned TAG_DEPTH = DET_LAT + 1;
    localparam int unsigned TCW       = $clog2(TAG_DEPTH + 1);
    localparam int unsigned RCW       = $clog2(OFIFO_DEPTH + 1);

    state_t           state_q, state_d;
    logic [7:0]       thr_q, thr_d;
    logic [SCR_W-1:0] min_q, min_d;
    logic [X_W-1:0]   x_q, x_d;
    logic [Y_W-1:0]   y_q, y_d;
    logic [18:0]      cnt_q, cnt_d;
    logic             err_q, err_d;

    tag_t             tag_wdata, tag_rdata;
    logic [TCW-1:0]   tag_count;
    logic             tag_empty, tag_full, tag_pop;
    corner_rec_t      rec_wdata, rec_rdata;
    logic [RCW-1:0]   rec_count;
    logic             rec_empty, rec_full, rec_push, rec_pop;
    logic [31:0]      ofifo_free;
    logic             accept, interior, last_pix, det_live;
    logic             unused_full;

    // Every tag in flight may still become a record, so it holds a record slot.
    assign ofifo_free = 32'(OFIFO_DEPTH) - 32'(rec_count);
    assign o_pix_rdy  = (state_q == StRun) && (ofifo_free > 32'(tag_count));
    assign accept     = i_pix_v && o_pix_rdy;
    assign interior   = (x_q >= X_W'(BORDER)) && (x_q <= X_W'(IMG_W - BORDER - 1)) &&
                        (y_q >= Y_W'(BORDER)) && (y_q <= Y_W'(IMG_H - BORDER - 1));
    assign last_pix   = (x_q == X_W'(IMG_W - 1)) && (y_q == Y_W'(IMG_H - 1));
    assign o_det_v    = accept && interior;
    assign tag_wdata  = '{x: x_q, y: y_q};

    // Results landing in IDLE belong to an aborted frame and are dropped silently.
    assign det_live  = i_det_v && (state_q != StIdle) && !i_abort;
    assign tag_pop   = det_live && !tag_empty;
    assign rec_push  = tag_pop && i_det_corner && (i_det_scr >= min_q);
    assign rec_wdata = '{x: tag_rdata.x, y: tag_rdata.y, scr: i_det_scr};
    assign rec_pop   = o_crn_v && i_crn_rdy;

    assign o_det_thr   = thr_q;
    assign o_crn_v     = !rec_empty;
    assign o_crn_x     = rec_rdata.x;
    assign o_crn_y     = rec_rdata.y;
    assign o_crn_scr   = rec_rdata.scr;
    assign o_busy      = (state_q != StIdle);
    assign o_done      = (state_q == StDone);
    assign o_crn_count = cnt_q;
    assign o_err       = err_q;
    assign unused_full = tag_full | rec_full;

    always_comb begin
        state_d = state_q;
        thr_d   = thr_q;
        min_d   = min_q;
        x_d     = x_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        if (accept) begin
            if (x_q == X_W'(IMG_W - 1)) begin
                x_d = '0;
                y_d = y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
        if (rec_push && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
        if (det_live && tag_empty) err_d = 1'b1;
        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    state_d = StRun;
                    thr_d   = i_thr;
                    min_d   = i_min_score;
                    x_d     = '0;
                    y_d     = '0;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            StRun:   if (accept && last_pix) state_d = StDrain;
            StDrain: if (tag_empty && rec_empty) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (i_abort) state_d = StIdle;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
            thr_q   <= '0;
            min_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            thr_q   <= thr_d;
            min_q   <= min_d;
            x_q     <= x_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    fast_sync_fifo #(
        .WIDTH ($bits(tag_t)),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk_i   (i_clk),
        .rst_ni  (i_rst_n),
        .flush_i (i_abort),
        .push_i  (o_det_v),
        .wdata_i (tag_wdata),
        .pop_i   (tag_pop),
        .rdata_o (tag_rdata),
        .count_o (tag_count),
        .full_o  (tag_full),
        .empty_o (tag_empty)
    );

    fast_sync_fifo #(
        .WIDTH ($bits(corner_rec_t)),
        .DEPTH (OFIFO_DEPTH)
    ) u_rec_fifo (
        .clk_i   (i_clk),
        .rst_ni  (i_rst_n),
        .flush_i (i_abort),
        .push_i  (rec_push),
        .wdata_i (rec_wdata),
        .pop_i   (rec_pop),
        .rdata_o (rec_rdata),
        .count_o (rec_count),
        .full_o  (rec_full),
        .empty_o (rec_empty)
    );

endmodule
